wb_stage: RTL and testbench

- Writeback stage directly upstream of the register file; the only producer of the regfile write port (we/waddr/wdata).
- Merges two result sources:
  - the in-order memory-stage result (ALU/load), which always has priority;
  - the multi-cycle mul/div unit, whose results are queued in a small FIFO and drained into idle write slots.
- Keeps a pending-register scoreboard so decode can stall on registers owned by outstanding mul/div operations.

---
 rtl/wb_stage.sv | 126 ++++++++++++
 tb/tb_wb_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wb_stage                                                          |
// | Brief  : Writeback merge of mem-stage and queued mul/div results, plus a   |
// |          pending-register scoreboard. WB_FWD_EN adds an operand bypass.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mem_valid,
  input  logic                          mem_we,
  input  logic [4:0]                    mem_rd,
  input  logic [XLEN-1:0]               mem_wdata,
  input  logic                          md_issue,
  input  logic [4:0]                    md_issue_rd,
  input  logic                          md_valid,
  output logic                          md_ready,
  input  logic [4:0]                    md_rd,
  input  logic [XLEN-1:0]               md_wdata,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [XLEN-1:0]               rf_wdata,
  output logic [31:0]                   pend_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]                    rs1,
  input  logic [4:0]                    rs2,
  input  logic [XLEN-1:0]               rf_rdata1,
  input  logic [XLEN-1:0]               rf_rdata2,
  output logic [XLEN-1:0]               op1,
  output logic [XLEN-1:0]               op2
`endif
);

  localparam int               c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W+1)'(FIFO_DEPTH);

  logic [4:0]         r_fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_PTR_W:0]   r_cnt;
  logic [31:0]        r_pend;

  logic               w_mem_wr;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [4:0]         w_head_rd;
  logic [31:0]        w_set;
  logic [31:0]        w_clr;

  assign w_mem_wr  = mem_valid & mem_we & (mem_rd != 5'd0);
  assign w_full    = (r_cnt == c_FULL);
  assign w_empty   = (r_cnt == '0);
  assign md_ready  = ~w_full & rst_n;
  assign w_push    = md_valid & md_ready;
  // Memory-stage results always win the write port; the queue only fills gaps.
  assign w_pop     = ~w_mem_wr & ~w_empty;
  assign w_head_rd = r_fifo_rd[r_head];
  assign w_set     = (md_issue && md_issue_rd != 5'd0) ? (32'd1 << md_issue_rd) : 32'd0;
  assign w_clr     = w_pop ? (32'd1 << w_head_rd) : 32'd0;

  assign pend_mask = r_pend;
  assign fifo_cnt  = r_cnt;

  // Storage needs no reset: occupancy is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_tail]   <= md_rd;
      r_fifo_data[r_tail] <= md_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_cnt    <= '0;
      r_pend   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_mem_wr) begin
        rf_we    <= 1'b1;
        rf_waddr <= mem_rd;
        rf_wdata <= mem_wdata;
      end else if (!w_empty) begin
        rf_we    <= (w_head_rd != 5'd0);
        rf_waddr <= w_head_rd;
        rf_wdata <= r_fifo_data[r_head];
      end else begin
        rf_we    <= 1'b0;
      end

      // Set is applied after clear so a same-cycle re-issue keeps the bit.
      r_pend <= ((r_pend & ~w_clr) | w_set) & 32'hFFFF_FFFE;
    end
  end

`ifdef WB_FWD_EN
  assign op1 = (rf_we && rf_waddr == rs1 && rs1 != 5'd0) ? rf_wdata : rf_rdata1;
  assign op2 = (rf_we && rf_waddr == rs2 && rs2 != 5'd0) ? rf_wdata : rf_rdata2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// Testbench for wb_stage: directed plus random stimulus against a queue-based
// reference model, checked by an independent monitor every cycle.
module tb_wb_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     mem_valid, mem_we, md_issue, md_valid, md_ready, rf_we;
  logic [4:0]               mem_rd, md_issue_rd, md_rd, rf_waddr;
  logic [XLEN-1:0]          mem_wdata, md_wdata, rf_wdata;
  logic [31:0]              pend_mask;
  logic [$clog2(DEPTH):0]   fifo_cnt;
`ifdef WB_FWD_EN
  logic [4:0]               rs1, rs2;
  logic [XLEN-1:0]          rf_rdata1, rf_rdata2, op1, op2;
`endif

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_wdata(mem_wdata),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_wdata(md_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
`ifdef WB_FWD_EN
    , .rs1(rs1), .rs2(rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .op1(op1), .op2(op2)
`endif
  );

  typedef struct {
    bit        rst_n, mem_valid, mem_we, md_issue, md_valid;
    bit [4:0]  mem_rd, md_issue_rd, md_rd;
    bit [31:0] mem_wdata, md_wdata;
  } in_t;

  typedef struct {
    bit        we, ready;
    bit [4:0]  addr;
    bit [31:0] data, pend;
    int        cnt;
  } exp_t;

  exp_t      exp_q[$];
  bit [4:0]  m_rd_q[$];
  bit [31:0] m_data_q[$];
  bit [31:0] m_pend;
  bit        m_we;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  int        tests = 0;
  int        fails = 0;
  int        cyc   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endfunction

  // Reference: a result queue, a pending bit per register, last write port value.
  task automatic model_step(in_t s);
    exp_t      e;
    bit        mem_wr;
    int        pre;
    bit [4:0]  r;
    bit [31:0] d;
    bit [31:0] np;
    mem_wr = s.mem_valid && s.mem_we && s.mem_rd != 0;
    if (!s.rst_n) begin
      m_rd_q.delete(); m_data_q.delete();
      m_pend = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      pre = m_rd_q.size();
      np  = m_pend;
      if (mem_wr) begin
        m_we = 1; m_addr = s.mem_rd; m_data = s.mem_wdata;
      end else if (pre > 0) begin
        r = m_rd_q.pop_front();
        d = m_data_q.pop_front();
        m_we = (r != 0); m_addr = r; m_data = d;
        np[r] = 1'b0;
      end else begin
        m_we = 0;
      end
      if (s.md_valid && pre < DEPTH) begin
        m_rd_q.push_back(s.md_rd);
        m_data_q.push_back(s.md_wdata);
      end
      if (s.md_issue && s.md_issue_rd != 0) np[s.md_issue_rd] = 1'b1;
      np[0] = 1'b0;
      m_pend = np;
    end
    e.we = m_we; e.addr = m_addr; e.data = m_data; e.pend = m_pend;
    e.cnt = m_rd_q.size();
    e.ready = (m_rd_q.size() < DEPTH) && s.rst_n;
    exp_q.push_back(e);
  endtask

  task automatic drive(in_t s);
    @(negedge clk);
    rst_n = s.rst_n; mem_valid = s.mem_valid; mem_we = s.mem_we; mem_rd = s.mem_rd;
    mem_wdata = s.mem_wdata; md_issue = s.md_issue; md_issue_rd = s.md_issue_rd;
    md_valid = s.md_valid; md_rd = s.md_rd; md_wdata = s.md_wdata;
`ifdef WB_FWD_EN
    rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    rf_rdata1 = $urandom; rf_rdata2 = $urandom;
`endif
    model_step(s);
  endtask

  function automatic in_t idle();
    in_t s;
    s = '{default: 0};
    s.rst_n = 1;
    return s;
  endfunction

  // Monitor: one expected record per clock edge, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_we", 32'(rf_we), 32'(e.we));
        chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
        chk("rf_wdata", rf_wdata, e.data);
        chk("pend_mask", pend_mask, e.pend);
        chk("fifo_cnt", 32'(fifo_cnt), 32'(e.cnt));
        chk("md_ready", 32'(md_ready), 32'(e.ready));
`ifdef WB_FWD_EN
        chk("op1", op1, (e.we && e.addr == rs1 && rs1 != 0) ? e.data : rf_rdata1);
        chk("op2", op2, (e.we && e.addr == rs2 && rs2 != 0) ? e.data : rf_rdata2);
`endif
      end
    end
  end

  initial begin
    in_t s;
    rst_n = 0; mem_valid = 0; mem_we = 0; mem_rd = 0; mem_wdata = 0;
    md_issue = 0; md_issue_rd = 0; md_valid = 0; md_rd = 0; md_wdata = 0;
`ifdef WB_FWD_EN
    rs1 = 0; rs2 = 0; rf_rdata1 = 0; rf_rdata2 = 0;
`endif
    s = idle(); s.rst_n = 0;
    repeat (2) drive(s);

    // Memory-stage write, then a bubble.
    s = idle(); s.mem_valid = 1; s.mem_we = 1; s.mem_rd = 5; s.mem_wdata = 32'hDEADBEEF;
    drive(s); drive(idle());

    // Issue x7, then its result drains two edges after the push.
    s = idle(); s.md_issue = 1; s.md_issue_rd = 7; drive(s); drive(idle());
    s = idle(); s.md_valid = 1; s.md_rd = 7; s.md_wdata = 32'h12345678; drive(s);
    repeat (2) drive(idle());

    // Fill the queue behind four mem writes, then let it drain.
    s = idle(); s.md_issue = 1; s.md_issue_rd = 3; drive(s);
    s.md_issue_rd = 4; drive(s);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.mem_valid = 1; s.mem_we = 1; s.mem_rd = 5'(10 + i); s.mem_wdata = 32'(i);
      if (i < 3) begin s.md_valid = 1; s.md_rd = (i == 0) ? 5'd3 : 5'd4; s.md_wdata = 32'hC0DE0000 + 32'(i); end
      drive(s);
    end
    repeat (3) drive(idle());

    // Writes to x0 never reach the regfile, but the queue entry is consumed.
    s = idle(); s.mem_valid = 1; s.mem_we = 1; s.mem_rd = 0; s.mem_wdata = 32'h1;
    s.md_valid = 1; s.md_rd = 0; s.md_wdata = 32'h2; drive(s);
    repeat (2) drive(idle());

    // Reset while the queue is full and registers are pending.
    s = idle(); s.md_issue = 1; s.md_issue_rd = 9; s.mem_valid = 1; s.mem_we = 1;
    s.mem_rd = 1; s.md_valid = 1; s.md_rd = 9; s.md_wdata = 32'h99; drive(s);
    s.md_issue = 0; drive(s);
    s = idle(); s.rst_n = 0; drive(s);
    repeat (3) drive(idle());

    for (int i = 0; i < 3000; i++) begin
      s.rst_n       = ($urandom_range(0, 99) != 0);
      s.mem_valid   = $urandom_range(0, 1);
      s.mem_we      = ($urandom_range(0, 3) != 0);
      s.mem_rd      = 5'($urandom_range(0, 7));
      s.mem_wdata   = $urandom;
      s.md_issue    = ($urandom_range(0, 9) < 3);
      s.md_issue_rd = 5'($urandom_range(0, 31));
      s.md_valid    = ($urandom_range(0, 9) < 4);
      s.md_rd       = 5'($urandom_range(0, 7));
      s.md_wdata    = $urandom;
      drive(s);
    end
    repeat (2) drive(idle());
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
